// File: rtl/any1_icache_pkg.sv
// Shared types and helpers for the any1 N-way instruction cache.
package any1_icache_pkg;

  localparam int FAULT_W   = 3;
  localparam int PLRU_MAXW = 7;

  typedef enum logic [1:0] {IDLE, REQ, WRITE} ic_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Tree PLRU, heap layout: node n (1-based) lives in bit n-1, a 1 steers right.
  // Leaves are nodes ways..2*ways-1, i.e. way w is leaf node ways+w.
  function automatic logic [2:0] plru_victim(input logic [PLRU_MAXW-1:0] bits, input int ways);
    int node;
    node = 1;
    for (int l = 0; l < 3; l++)
      if (node < ways) node = 2 * node + int'(bits[3'(node - 1)]);
    return 3'(node - ways);
  endfunction

  // Walk from the used leaf to the root, pointing every node on the path away from it.
  function automatic logic [PLRU_MAXW-1:0] plru_update(input logic [PLRU_MAXW-1:0] bits,
                                                       input int ways, input logic [2:0] way);
    int node;
    logic [PLRU_MAXW-1:0] r;
    r    = bits;
    node = ways + int'(way);
    for (int l = 0; l < 3; l++)
      if (node > 1) begin
        r[3'(node / 2 - 1)] = ~node[0];
        node = node / 2;
      end
    return r;
  endfunction

endpackage

// File: rtl/any1_icache_way.sv
// One way of the instruction cache: tag/data/fault/valid arrays with async read.
module any1_icache_way
  import any1_icache_pkg::*;
#(
  parameter int pSets     = 64,
  parameter int pLineBits = 512,
  parameter int TAG_W     = 52,
  parameter int IB        = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IB-1:0]        rd_idx,
  input  logic [TAG_W-1:0]     rd_tag,
  output logic                 match,
  output logic [pLineBits-1:0] rd_dat,
  output logic [FAULT_W-1:0]   rd_fault,
  input  logic                 inv_all,
  input  logic                 inv_line,
  input  logic                 wr,
  input  logic [IB-1:0]        wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [pLineBits-1:0] wr_dat,
  input  logic [FAULT_W-1:0]   wr_fault,
  input  logic                 wr_valid,
  output logic                 wr_slot_valid
);

  logic [TAG_W-1:0]     tag_mem   [pSets];
  logic [pLineBits-1:0] dat_mem   [pSets];
  logic [FAULT_W-1:0]   fault_mem [pSets];
  logic [pSets-1:0]     valid;

  assign match         = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_dat        = dat_mem[rd_idx];
  assign rd_fault      = fault_mem[rd_idx];
  assign wr_slot_valid = valid[wr_idx];

  // Line payload write; contents are meaningless until the valid bit says otherwise.
  always_ff @(posedge clk) begin
    if (wr) begin
      tag_mem[wr_idx]   <= wr_tag;
      dat_mem[wr_idx]   <= wr_dat;
      fault_mem[wr_idx] <= wr_fault;
    end
  end

  // Valid bits: global invalidate beats everything; a fill write lands after a line invalidate.
  always_ff @(posedge clk) begin
    if (rst || inv_all) begin
      valid <= '0;
    end else begin
      if (inv_line && match) valid[rd_idx] <= 1'b0;
      if (wr)                valid[wr_idx] <= wr_valid;
    end
  end

endmodule

// File: rtl/any1_icache_nway.sv
// N-way set-associative L1 instruction cache with built-in line-fill controller.
module any1_icache_nway
  import any1_icache_pkg::*;
#(
  parameter int pWays     = 4,
  parameter int pSets     = 64,
  parameter int pLineBits = 512,
  parameter int AMSB      = 63,
  parameter int pRepl     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd,
  input  logic [AMSB:0]        adr,
  output logic                 hit,
  output logic [pLineBits-1:0] o,
  output logic [FAULT_W-1:0]   fault_o,
  output logic                 busy,
  input  logic                 invall,
  input  logic                 invline,
  output logic                 mem_req,
  output logic [AMSB:0]        mem_adr,
  input  logic                 mem_ack,
  input  logic [pLineBits-1:0] mem_dat,
  input  logic [FAULT_W-1:0]   mem_fault
);

  localparam int pOB   = clog2(pLineBits / 8);
  localparam int IB    = clog2(pSets);
  localparam int TAG_W = AMSB + 1 - pOB - IB;
  localparam int WB    = clog2(pWays);
  localparam int PW    = pWays - 1;

  logic [IB-1:0]        idx, fill_idx;
  logic [TAG_W-1:0]     tag, fill_tag;
  logic [pWays-1:0]     match, slot_vld, way_we;
  logic [pLineBits-1:0] way_dat   [pWays];
  logic [FAULT_W-1:0]   way_fault [pWays];
  ic_state_t            state;
  logic                 stale, wr;
  logic [pLineBits-1:0] fill_dat;
  logic [FAULT_W-1:0]   fill_fault;
  logic [PW-1:0]        plru [pSets];
  logic [15:0]          lfsr;
  logic [WB-1:0]        hit_way, victim;
  logic [PLRU_MAXW-1:0] plru_hit_nxt, plru_fill_base, plru_fill_nxt;
  logic                 unused_adr;

  assign idx        = adr[pOB+IB-1:pOB];
  assign tag        = adr[AMSB:pOB+IB];
  assign fill_idx   = mem_adr[pOB+IB-1:pOB];
  assign fill_tag   = mem_adr[AMSB:pOB+IB];
  assign wr         = (state == WRITE);
  assign busy       = (state != IDLE);
  assign unused_adr = ^adr[pOB-1:0];

  for (genvar g = 0; g < pWays; g++) begin : g_way
    any1_icache_way #(
      .pSets(pSets), .pLineBits(pLineBits), .TAG_W(TAG_W), .IB(IB)
    ) u_way (
      .clk(clk), .rst(rst),
      .rd_idx(idx), .rd_tag(tag),
      .match(match[g]), .rd_dat(way_dat[g]), .rd_fault(way_fault[g]),
      .inv_all(invall), .inv_line(invline),
      .wr(way_we[g]), .wr_idx(fill_idx), .wr_tag(fill_tag),
      .wr_dat(fill_dat), .wr_fault(fill_fault), .wr_valid(!stale),
      .wr_slot_valid(slot_vld[g])
    );
  end

  // Hit detect and output mux; the lowest-numbered matching way wins.
  always_comb begin
    hit_way = '0;
    o       = '0;
    fault_o = '0;
    for (int w = pWays - 1; w >= 0; w--)
      if (match[w]) hit_way = WB'(w);
    hit = rd && (|match);
    if (hit) begin
      o       = way_dat[hit_way];
      fault_o = way_fault[hit_way];
    end
  end

  // Victim choice and PLRU next values; a same-set hit is folded in before the fill update.
  always_comb begin
    if (pRepl == 1) victim = WB'(plru_victim(PLRU_MAXW'(plru[fill_idx]), pWays));
    else            victim = lfsr[WB-1:0];
    for (int w = pWays - 1; w >= 0; w--)
      if (!slot_vld[w]) victim = WB'(w);
    for (int w = 0; w < pWays; w++)
      way_we[w] = wr && (victim == WB'(w));
    plru_hit_nxt   = plru_update(PLRU_MAXW'(plru[idx]), pWays, 3'(hit_way));
    plru_fill_base = (hit && idx == fill_idx) ? plru_hit_nxt : PLRU_MAXW'(plru[fill_idx]);
    plru_fill_nxt  = plru_update(plru_fill_base, pWays, 3'(victim));
  end

  // Replacement state: touched on every hit and every fill write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < pSets; s++) plru[s] <= '0;
    end else begin
      if (hit) plru[idx]      <= PW'(plru_hit_nxt);
      if (wr)  plru[fill_idx] <= PW'(plru_fill_nxt);
    end
  end

  // Free-running LFSR for random replacement.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'h0001;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Fill line capture on the acknowledged beat.
  always_ff @(posedge clk) begin
    if (state == REQ && mem_ack) begin
      fill_dat   <= mem_dat;
      fill_fault <= mem_fault;
    end
  end

  // Miss-fill controller: request a line, wait for ack, write it the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      mem_adr <= '0;
      stale   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          stale <= 1'b0;
          if (rd && !hit && !invall) begin
            state   <= REQ;
            mem_req <= 1'b1;
            mem_adr <= {adr[AMSB:pOB], {pOB{1'b0}}};
          end
        end
        REQ: begin
          stale <= stale | invall;
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= WRITE;
          end
        end
        WRITE: begin
          stale <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_any1_icache_nway.sv
// Directed bench for any1_icache_nway (4 ways, 64 sets, 512-bit lines, tree PLRU).
module tb_any1_icache_nway;

  localparam int W = 4;
  localparam int S = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd = 1'b0, invall = 1'b0, invline = 1'b0, mem_ack = 1'b0;
  logic [63:0]  adr = '0;
  logic [511:0] mem_dat = '0;
  logic [2:0]   mem_fault = '0;
  logic         hit, busy, mem_req;
  logic [511:0] o;
  logic [2:0]   fault_o;
  logic [63:0]  mem_adr;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  any1_icache_nway #(.pWays(W), .pSets(S), .pLineBits(512), .AMSB(63), .pRepl(1)) dut (
    .clk(clk), .rst(rst), .rd(rd), .adr(adr), .hit(hit), .o(o), .fault_o(fault_o),
    .busy(busy), .invall(invall), .invline(invline), .mem_req(mem_req), .mem_adr(mem_adr),
    .mem_ack(mem_ack), .mem_dat(mem_dat), .mem_fault(mem_fault)
  );

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  function automatic logic [511:0] mkd(input int k);
    return {16{32'hC0DE0000 | 32'(k)}};
  endfunction

  // ---------------- behavioural model ----------------
  bit           mv [S][W];
  logic [51:0]  mt [S][W];
  logic [511:0] md [S][W];
  logic [2:0]   mf [S][W];
  bit           pb0 [S];   // 0: victim among ways 0/1, 1: among ways 2/3
  bit           pb1 [S];   // within 0/1: 1 means way 1 is the victim
  bit           pb2 [S];   // within 2/3: 1 means way 3 is the victim
  int           mphase;    // 0 idle, 1 waiting for ack, 2 writing
  logic [63:0]  madr;
  logic [511:0] mfd;
  logic [2:0]   mff;
  bit           mstale;

  function automatic int m_lookup(input logic [63:0] a);
    int s;
    s = int'(a[11:6]);
    for (int w = 0; w < W; w++)
      if (mv[s][w] && mt[s][w] == a[63:12]) return w;
    return -1;
  endfunction

  function automatic void m_touch(input int s, input int w);
    if (w < 2) begin pb0[s] = 1'b1; pb1[s] = (w == 0); end
    else       begin pb0[s] = 1'b0; pb2[s] = (w == 2); end
  endfunction

  function automatic int m_victim(input int s);
    for (int w = 0; w < W; w++)
      if (!mv[s][w]) return w;
    if (!pb0[s]) return pb1[s] ? 1 : 0;
    return pb2[s] ? 3 : 2;
  endfunction

  task automatic compare();
    int hw, s;
    s  = int'(adr[11:6]);
    hw = rd ? m_lookup(adr) : -1;
    chk("hit", 512'(hit), 512'(hw >= 0));
    chk("o", o, (hw >= 0) ? md[s][hw] : 512'(0));
    chk("fault_o", 512'(fault_o), (hw >= 0) ? 512'(mf[s][hw]) : 512'(0));
    chk("busy", 512'(busy), 512'(mphase != 0));
    chk("mem_req", 512'(mem_req), 512'(mphase == 1));
    chk("mem_adr", 512'(mem_adr), 512'(madr));
  endtask

  task automatic model_step();
    int s, hw, fs, vic;
    if (rst) begin
      for (int i = 0; i < S; i++) begin
        for (int w = 0; w < W; w++) mv[i][w] = 1'b0;
        pb0[i] = 1'b0; pb1[i] = 1'b0; pb2[i] = 1'b0;
      end
      mphase = 0; madr = '0; mstale = 1'b0;
      return;
    end
    s   = int'(adr[11:6]);
    hw  = rd ? m_lookup(adr) : -1;
    fs  = int'(madr[11:6]);
    vic = (mphase == 2) ? m_victim(fs) : 0;
    if (hw >= 0) m_touch(s, hw);
    if (mphase == 2) m_touch(fs, vic);
    if (invall) begin
      for (int i = 0; i < S; i++)
        for (int w = 0; w < W; w++) mv[i][w] = 1'b0;
    end else begin
      if (invline)
        for (int w = 0; w < W; w++)
          if (mv[s][w] && mt[s][w] == adr[63:12]) mv[s][w] = 1'b0;
      if (mphase == 2) begin
        mv[fs][vic] = !mstale;
        mt[fs][vic] = madr[63:12];
        md[fs][vic] = mfd;
        mf[fs][vic] = mff;
      end
    end
    case (mphase)
      0: begin
        mstale = 1'b0;
        if (rd && hw < 0 && !invall) begin
          mphase = 1;
          madr   = {adr[63:6], 6'b0};
        end
      end
      1: begin
        if (invall) mstale = 1'b1;
        if (mem_ack) begin mfd = mem_dat; mff = mem_fault; mphase = 2; end
      end
      default: begin mphase = 0; mstale = 1'b0; end
    endcase
  endtask

  // Per-cycle comparison just before the rising edge, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (chk_en) compare();
      model_step();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic ack_fill(input logic [511:0] d, input logic [2:0] f);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    if (!mem_req) begin
      chk("ack_wait", 512'(0), 512'(1));
      return;
    end
    mem_ack = 1'b1; mem_dat = d; mem_fault = f;
    @(negedge clk);
    mem_ack = 1'b0; mem_dat = '1;
    @(negedge clk);
  endtask

  task automatic issue_miss(input logic [63:0] a);
    @(negedge clk); rd = 1'b1; adr = a;
    @(negedge clk); rd = 1'b0;
  endtask

  task automatic fill(input logic [63:0] a, input logic [511:0] d, input logic [2:0] f);
    issue_miss(a);
    ack_fill(d, f);
  endtask

  task automatic lookup(input logic [63:0] a, input logic exp_hit, input bit chk_o,
                        input logic [511:0] exp_o, input string nm);
    @(negedge clk); rd = 1'b1; adr = a;
    #3;
    chk({nm, "_hit"}, 512'(hit), 512'(exp_hit));
    if (chk_o) chk({nm, "_o"}, o, exp_o);
    @(negedge clk); rd = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // Reset state and first miss
    rst = 1'b0; chk_en = 1'b1; rd = 1'b1; adr = 64'h1000;
    #3;
    chk("rst_hit", 512'(hit), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_req", 512'(mem_req), 512'(0));
    chk("rst_adr", 512'(mem_adr), 512'(0));
    @(negedge clk); rd = 1'b0;
    #3;
    chk("t1_req", 512'(mem_req), 512'(1));
    chk("t1_adr", 512'(mem_adr), 512'(64'h1000));
    ack_fill(mkd(0), 3'd0);
    lookup(64'h1000, 1'b1, 1'b1, mkd(0), "t1");

    // PLRU replacement in set 0
    fill(64'h2000, mkd(2), 3'd0);
    fill(64'h3000, mkd(3), 3'd0);
    fill(64'h4000, mkd(4), 3'd0);
    lookup(64'h1000, 1'b1, 1'b1, mkd(0), "t2_touch0");
    fill(64'h5000, mkd(5), 3'd0);
    lookup(64'h1000, 1'b1, 1'b1, mkd(0), "t2_old0");
    lookup(64'h5000, 1'b1, 1'b1, mkd(5), "t2_new");
    lookup(64'h2000, 1'b1, 1'b0, '0, "t2_w1");
    lookup(64'h4000, 1'b1, 1'b0, '0, "t2_w3");
    lookup(64'h3000, 1'b0, 1'b0, '0, "t2_evicted");
    ack_fill(mkd(33), 3'd0);

    // Line invalidate
    fill(64'h2040, mkd(20), 3'd0);
    fill(64'h3040, mkd(30), 3'd0);
    @(negedge clk); invline = 1'b1; adr = 64'h2040;
    @(negedge clk); invline = 1'b0;
    lookup(64'h3040, 1'b1, 1'b1, mkd(30), "t3_other");
    lookup(64'h2040, 1'b0, 1'b0, '0, "t3_inv");
    ack_fill(mkd(21), 3'd0);
    lookup(64'h2040, 1'b1, 1'b1, mkd(21), "t3_refill");

    // Fault code and hit while a fill is outstanding
    fill(64'h7000, mkd(70), 3'd5);
    @(negedge clk); rd = 1'b1; adr = 64'h7000;
    #3;
    chk("t6_fault", 512'(fault_o), 512'(5));
    @(negedge clk); rd = 1'b0;
    issue_miss(64'h7040);
    rd = 1'b1; adr = 64'h7000;
    #3;
    chk("t6_busy", 512'(busy), 512'(1));
    chk("t6_hit", 512'(hit), 512'(1));
    chk("t6_o", o, mkd(70));
    @(negedge clk); rd = 1'b0;
    ack_fill(mkd(71), 3'd2);
    lookup(64'h7040, 1'b1, 1'b1, mkd(71), "t6_fill");

    // Invalidate-all during an outstanding fill
    issue_miss(64'h5080);
    invall = 1'b1;
    @(negedge clk); invall = 1'b0;
    ack_fill(mkd(50), 3'd0);
    lookup(64'h5080, 1'b0, 1'b0, '0, "t4_stale");
    ack_fill(mkd(51), 3'd0);
    lookup(64'h5080, 1'b1, 1'b1, mkd(51), "t4_refetch");
    lookup(64'h7000, 1'b0, 1'b0, '0, "t4_flushed");
    ack_fill(mkd(72), 3'd0);

    // Reset during a request, then a late ack
    issue_miss(64'h6000);
    #3;
    chk("t5_req", 512'(mem_req), 512'(1));
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #3;
    chk("t5_req_drop", 512'(mem_req), 512'(0));
    @(negedge clk); mem_ack = 1'b1; mem_dat = mkd(60);
    @(negedge clk); mem_ack = 1'b0;
    #3;
    chk("t5_busy", 512'(busy), 512'(0));
    lookup(64'h5080, 1'b0, 1'b0, '0, "t5_miss");
    ack_fill(mkd(61), 3'd0);
    lookup(64'h5080, 1'b1, 1'b1, mkd(61), "t5_refill");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
